// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit: one-at-a-time load/store sequencer to byte-addressed memory; define MEM_ALIGN_CHECK_EN to reject misaligned accesses
module mips_mem_access_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_active,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [2:0] op_q, lat_cnt;
  logic [31:0] addr_q, wdata_q, rdata_q, ext;
  logic err_q, mis, is_store, last;
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (req_op == 3'd4 || req_op == 3'd7) ? |req_addr[1:0] :
               (req_op == 3'd2 || req_op == 3'd3 || req_op == 3'd6) ? req_addr[0] : 1'b0;
`else
  assign mis = 1'b0;
`endif
  assign is_store = op_q > 3'd4;
  assign last = lat_cnt == 3'(READ_LATENCY - 1);
  // sign/zero extension of the returned memory word by load type
  always_comb
    ext = op_q == 3'd0 ? {{24{mem_data_out[7]}}, mem_data_out[7:0]} :
          op_q == 3'd1 ? {24'b0, mem_data_out[7:0]} :
          op_q == 3'd2 ? {{16{mem_data_out[15]}}, mem_data_out[15:0]} :
          op_q == 3'd3 ? {16'b0, mem_data_out[15:0]} : mem_data_out;
  // next-state: misaligned requests skip straight to the response
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (req_valid ? (mis ? RESP : ISSUE) : IDLE) :
               state == ISSUE ? (is_store ? RESP : WAIT) :
               state == WAIT  ? (last ? RESP : WAIT) :
               (resp_ready ? IDLE : RESP);
  end
  // state, captured request, latency counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      lat_cnt <= 3'd0;
    end else begin
      state   <= state_nx;
      lat_cnt <= state == WAIT ? lat_cnt + 3'd1 : 3'd0;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= 32'd0;
        err_q   <= mis;
      end
      if (state == WAIT && last) rdata_q <= ext;
    end
  end
  // outputs are forced quiet combinationally while reset is high so no strobe leaks in the reset cycle
  assign req_ready   = state == IDLE && !reset;
  assign resp_valid  = state == RESP && !reset;
  assign resp_rdata  = reset ? 32'd0 : rdata_q;
  assign resp_err    = err_q && !reset;
  assign mem_active  = !reset;
  assign mem_address = reset ? 32'd0 : addr_q;
  assign mem_data_in = reset ? 32'd0 : wdata_q;
  assign mem_wr_en   = state == ISSUE && is_store && !reset;
  assign mem_read_en = state == ISSUE && !is_store && !reset;
  assign mem_byte_en = !mem_wr_en ? 4'b0000 : op_q == 3'd5 ? 4'b0001 : op_q == 3'd6 ? 4'b0011 : 4'b1111;
endmodule

// File: tb/tb_mips_mem_access_unit.sv
// tb_mips_mem_access_unit: randomized load/store traffic against a byte-array reference model
module tb_mips_mem_access_unit;
  localparam int LAT = 3;
  logic clk = 1'b0, reset, req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic mem_active, mem_wr_en, mem_read_en;
  logic [2:0] req_op;
  logic [3:0] mem_byte_en;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_address, mem_data_in, mem_data_out;
  int n_tests = 0, n_fail = 0;
  logic [7:0] env_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256];
  logic [31:0] pipe [LAT];
  logic [31:0] r;

  always #5 clk = ~clk;

  mips_mem_access_unit #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_active(mem_active), .mem_address(mem_address),
    .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en), .mem_byte_en(mem_byte_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // behavioural data memory: byte-enabled writes, reads returned LAT cycles after the strobe
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wr_en && mem_byte_en[i]) env_mem[8'(mem_address + i)] <= mem_data_in[8*i +: 8];
    pipe[0] <= mem_read_en ? {env_mem[8'(mem_address + 3)], env_mem[8'(mem_address + 2)],
                              env_mem[8'(mem_address + 1)], env_mem[8'(mem_address)]} : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_out = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic junk();
    req_valid = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd);
    int nb, cycles, wr, rdn;
    bit st, sg, mis;
    logic [31:0] exp, v;
    st = op >= 5;
    nb = (op == 4 || op == 7) ? 4 : (op == 2 || op == 3 || op == 6) ? 2 : 1;
    sg = op == 0 || op == 2;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (addr % nb) != 0;
`endif
    v = 0;
    for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[8'(addr + i)]) << (8 * i));
    if (sg && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
    exp = (st || mis) ? 32'd0 : v;
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    resp_ready = hold == 0;
    @(posedge clk);
    cycles = 0; wr = 0; rdn = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (mem_wr_en) begin
        wr++;
        chk("wr_byte_en", {28'd0, mem_byte_en}, 32'((1 << nb) - 1));
        chk("wr_address", mem_address, addr);
        chk("wr_data", mem_data_in, wd);
      end
      if (mem_read_en) begin
        rdn++;
        chk("rd_address", mem_address, addr);
        chk("rd_byte_en", {28'd0, mem_byte_en}, 32'd0);
      end
      if (resp_valid) break;
      chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
      junk();
    end
    chk("resp_latency", 32'(cycles), mis ? 32'd1 : st ? 32'd2 : 32'(2 + LAT));
    chk("wr_count", 32'(wr), (st && !mis) ? 32'd1 : 32'd0);
    chk("rd_count", 32'(rdn), (!st && !mis) ? 32'd1 : 32'd0);
    chk("resp_rdata", resp_rdata, exp);
    chk("resp_err", {31'd0, resp_err}, {31'd0, mis});
    rd = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      junk();
      @(negedge clk);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, exp);
      chk("hold_not_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    if (st && !mis)
      for (int i = 0; i < nb; i++) ref_mem[8'(addr + i)] = wd[8*i +: 8];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_active", {31'd0, mem_active}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_outputs", {resp_rdata | mem_address | mem_data_in}, 32'd0);
    chk("rst_strobes", {26'd0, resp_err, mem_wr_en, mem_read_en, mem_byte_en == 4'd0}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("active_after_rst", {31'd0, mem_active}, 32'd1);
    run_req(3'd7, 32'h10, 32'hDEADBEEF, 0, r);
    chk("sw_rdata", r, 32'd0);
    run_req(3'd0, 32'h13, 32'h0, 0, r);
    chk("lb_13", r, 32'hFFFFFFDE);
    run_req(3'd1, 32'h13, 32'h0, 1, r);
    chk("lbu_13", r, 32'h000000DE);
    run_req(3'd2, 32'h10, 32'h0, 0, r);
    chk("lh_10", r, 32'hFFFFBEEF);
    run_req(3'd4, 32'h10, 32'h0, 0, r);
    chk("lw_10", r, 32'hDEADBEEF);
    run_req(3'd6, 32'h11, 32'h1234, 4, r);
    run_req(3'd5, 32'h20, 32'h5A, 0, r);
    req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h20; req_wdata = 32'hA5;
    @(posedge clk);
    @(negedge clk);
    chk("issue_wr_en", {31'd0, mem_wr_en}, 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    #1;
    chk("rst_issue_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_issue_addr", mem_address, 32'd0);
    chk("rst_issue_active", {31'd0, mem_active}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_to_idle", {30'd0, req_ready, resp_valid}, 32'd2);
    @(negedge clk);
    run_req(3'd1, 32'h20, 32'h0, 0, r);
    chk("byte_kept", r, 32'h5A);
    for (int t = 0; t < 200; t++)
      run_req(3'($urandom), 32'($urandom_range(0, 63)), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, r);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
